mult_acc_stage: RTL

MULT_ACC_STAGE -- requirements
Module: mult_acc_stage

---
 rtl/mult_acc_stage_pkg.sv | 18 +
 rtl/mult_acc_stage_if.sv | 27 ++
 rtl/valid_delay.sv | 28 ++
 rtl/mult_acc_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mult_acc_stage_pkg.sv
// Shared constants and types for the multiply-accumulate stage.
package mult_pkg;

    localparam int LATENCY = 7;   // multiplier pipeline depth
    localparam int ACC_W   = 24;  // signed accumulator width
    localparam int PROD_W  = 19;  // signed product width
    localparam int LEN_W   = 8;   // products-per-sum field width

    // Saturation limits for the default accumulator width
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/mult_acc_stage_if.sv
// Product input and sum output bundle of the multiply-accumulate stage.
interface mult_acc_stage_if #(
    parameter int ACC_W = mult_pkg::ACC_W
);
    import mult_pkg::*;

    logic                     in_valid;
    logic signed [PROD_W-1:0] result;
    logic [LEN_W-1:0]         len;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ovf;

    // Upstream multiplier plus downstream consumer
    modport master (
        output in_valid, result, len, out_ready,
        input  out_valid, out_data, out_ovf
    );

    // The accumulate stage itself
    modport slave (
        input  in_valid, result, len, out_ready,
        output out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/valid_delay.sv
// Single-bit valid delay line matching the multiplier pipeline depth.
module valid_delay #(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout,
    output logic any
);

    logic [DEPTH-1:0] vld_pipe;

    // Shift the launch valid toward the result end; flush drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (flush)
            vld_pipe <= '0;
        else
            vld_pipe <= (vld_pipe << 1) | DEPTH'(din);
    end

    assign dout = vld_pipe[DEPTH-1];
    assign any  = |vld_pipe;

endmodule

// File: rtl/mult_acc_stage.sv
// Accumulates len saturating products per sum and queues sums in a 2-deep buffer.
module mult_acc_stage #(
    parameter int LATENCY = mult_pkg::LATENCY,
    parameter int ACC_W   = mult_pkg::ACC_W,
    parameter int OBUF_D  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    mult_acc_stage_if.slave  bus,
    output logic             overrun,
    output logic             busy
);
    import mult_pkg::*;

    // Limits follow the instance width so a non-default ACC_W still clamps correctly
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    ovf_q, ovf_d;
    logic                    pvalid, pipe_busy;
    logic                    done;
    logic signed [ACC_W-1:0] fin_data;
    logic                    fin_ovf;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   wide;
    logic signed [ACC_W-1:0] sat_sum;
    logic                    sat_ovf;

    // Output buffer
    logic [OBUF_D-1:0][ACC_W-1:0] mem_data;
    logic [OBUF_D-1:0]            mem_ovf;
    logic                         wr_ptr, rd_ptr;
    logic [1:0]                   fill;
    logic                         push, pop, full, push_ok, drop;

    valid_delay #(.DEPTH(LATENCY)) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .din   (bus.in_valid),
        .dout  (pvalid),
        .any   (pipe_busy)
    );

    // One guard bit above the accumulator exposes signed overflow
    always_comb begin
        prod_ext = ACC_W'(bus.result);
        wide     = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(bus.result);
        sat_ovf  = wide[ACC_W] != wide[ACC_W-1];
        sat_sum  = sat_ovf ? (wide[ACC_W] ? SAT_MIN : SAT_MAX) : wide[ACC_W-1:0];
    end

    // Accumulator datapath; a completing sum is handed out and the accumulator re-zeroed
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        done     = 1'b0;
        fin_data = '0;
        fin_ovf  = 1'b0;
        if (pvalid) begin
            if (state_q == ST_IDLE) begin
                acc_d = prod_ext;
                cnt_d = LEN_W'(1);
                ovf_d = 1'b0;
                len_d = (bus.len == '0) ? LEN_W'(1) : bus.len;
            end else begin
                acc_d = sat_sum;
                cnt_d = cnt_q + LEN_W'(1);
                ovf_d = ovf_q | sat_ovf;
            end
            if (cnt_d == len_d) begin
                done     = 1'b1;
                fin_data = acc_d;
                fin_ovf  = ovf_d;
                acc_d    = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end
        end
    end

    // Datapath registers; clear aborts the sum but keeps the latched length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else if (clear)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: completion returns to IDLE so the next product starts a fresh sum
    always_comb begin
        state_d = state_q;
        if (done)
            state_d = ST_IDLE;
        else if (pvalid)
            state_d = ST_ACCUM;
    end

    // Buffer control; a pop frees the slot in the same cycle so full+push+pop is lossless
    always_comb begin
        push    = done && !clear;
        pop     = bus.out_valid && bus.out_ready;
        full    = fill == 2'd2;
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    // Buffer storage and pointers; clear leaves queued sums untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data <= '0;
            mem_ovf  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fill     <= '0;
        end else begin
            if (push_ok) begin
                mem_data[wr_ptr] <= fin_data;
                mem_ovf[wr_ptr]  <= fin_ovf;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fill <= fill + {1'b0, push_ok} - {1'b0, pop};
        end
    end

    // Sticky record of a dropped sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (clear)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
    end

    // FSM/status outputs
    always_comb begin
        bus.out_valid = fill != 2'd0;
        bus.out_data  = mem_data[rd_ptr];
        bus.out_ovf   = mem_ovf[rd_ptr];
        busy          = (state_q == ST_ACCUM) || pipe_busy;
    end

endmodule
